parity_frame_checker: RTL
=========================

# parity_frame_checker

Parametrised frame-parity generator/checker with handshakes. It XOR-reduces a stream of WIDTH-bit words over a frame of up to FRAME_LEN words, then presents the frame parity, a mismatch flag and the word count on a valid/ready output. It sits between a dice/vote input capture stage and the result display/logging logic, and generalises the team's combinational three-input XOR parity cell.

## Interface
- WIDTH, 3, bits per input word (≥1)
- FRAME_LEN, 8, maximum words per frame (≥1); frame closes early on in_last
- ODD, 0, 0 = even parity (out_parity = XOR of all bits), 1 = odd parity (inverted)
- CW, $clog2(FRAME_LEN+1), derived; not overridden

- clk  input  1  rising-edge clock, the single clock for the block
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- flush  input  1  synchronous abort of the current frame, priority over all traffic
- in_valid  input  1  input word present
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  input word
- in_last  input  1  qualifies the last word of a frame
- in_exp  input  1  expected parity, sampled only with the last word
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream accepts the result
- out_parity  output  1  frame parity per ODD
- out_err  output  1  out_parity != sampled in_exp
- out_len  output  CW  words in the frame, 1..FRAME_LEN
- err_count  output  8  frames completed with out_err=1, saturates at 255

## Operation
- Two states: ACCUM and HOLD. Reset enters ACCUM.
- ACCUM: in_ready=1, out_valid=0. Accept = in_valid & in_ready. On accept: acc <= acc ^ (^in_data); cnt <= cnt+1.
- The frame ends on an accepted word with in_last=1, or when cnt == FRAME_LEN-1 at accept (forced close, in_last ignored). On that cycle: out_parity <= acc ^ (^in_data) ^ ODD; out_len <= cnt+1; out_err <= that parity != in_exp; err_count increments if out_err is set and the count is below 255; state -> HOLD.
- HOLD: in_ready=0, out_valid=1, outputs stable. On out_ready: acc, cnt <= 0; state -> ACCUM.
- flush (any state): acc, cnt <= 0; out_valid drops; state -> ACCUM. err_count is unchanged. The accept and result in that cycle are discarded.
- in_data, in_last and in_exp are don't-care when in_valid=0.
- cnt and out_len are CW bits wide; cnt never exceeds FRAME_LEN-1 in ACCUM.

## Timing
- Reset values: in_ready=1, out_valid=0, out_parity=0, out_err=0, out_len=0, err_count=0; internal acc=0, cnt=0, state ACCUM.
- Asynchronous reset mid-frame or mid-HOLD discards everything at once, including err_count.
- in_ready is a pure decode of the state, with no combinational path from out_ready.
- out_valid rises on the clock edge after the closing accept, so latency from the last word to the result is 1 cycle.
- Throughput: one word per cycle inside a frame. There is one idle cycle per frame in the best case: the HOLD cycle with out_ready=1, followed by the next accept.
- out_ready high during ACCUM has no effect.
- flush and out_ready together in HOLD: flush wins, with the same resulting state.
- A single-word frame (in_last on the first word) gives out_len=1.

## Test plan
- WIDTH=3, ODD=0: words 3'b101, 3'b011 (last), in_exp=1 -> 1 cycle later out_valid=1, out_parity=0, out_err=1, out_len=2, err_count=1.
- ODD=1: single word 3'b111 with in_last, in_exp=0 -> out_parity=0, out_err=0, out_len=1.
- FRAME_LEN=8: 8 words of 3'b001, in_last never asserted -> forced close, out_parity=0, out_len=8; in_ready=0 until out_ready.
- Hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout; on out_ready=1, in_ready=1 the next cycle and a new frame starts with acc=0.
- flush after 3 words, then a 1-word frame 3'b100 with in_last -> out_parity=1, out_len=1; err_count unchanged.
- 256 frames each with out_err=1 -> err_count=255 and holds at 255; rst_n pulsed low asynchronously mid-frame -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/parity_frame_checker.sv
// parity_frame_checker
//
// Frame-parity generator/checker. Words arriving on a valid/ready input are
// XOR-reduced over a frame of up to FRAME_LEN words. A frame closes on a word
// flagged with in_last, or on the FRAME_LEN-th word. The frame parity, a
// mismatch flag against the expected parity and the word count are then held
// on a valid/ready output until the consumer takes them.
//
// Parameters:
//   WIDTH     - bits per input word (>= 1)
//   FRAME_LEN - maximum words per frame (>= 1)
//   ODD       - 0: even parity (plain XOR of all bits), 1: odd parity (inverted)
//   CW        - derived width of the word counter and out_len
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   flush      - synchronous abort of the current frame or result, top priority
//   in_valid   - input word present
//   in_ready   - block can accept a word (high only while accumulating)
//   in_data    - input word
//   in_last    - marks the last word of a frame
//   in_exp     - expected frame parity, sampled only with the closing word
//   out_valid  - frame result valid
//   out_ready  - consumer takes the result
//   out_parity - frame parity according to ODD
//   out_err    - out_parity differs from the sampled in_exp
//   out_len    - number of words in the frame, 1..FRAME_LEN
//   err_count  - frames closed with out_err set, saturating at 255

module parity_frame_checker #(
    parameter  int WIDTH     = 3,
    parameter  int FRAME_LEN = 8,
    parameter  int ODD       = 0,
    localparam int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_err,
    output logic [CW-1:0]    out_len,
    output logic [7:0]       err_count
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic          ODD_BIT  = (ODD != 0);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    state_t        state;
    state_t        state_next;
    logic          acc;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          close_frame;
    logic          word_parity;
    logic          frame_parity;
    logic          frame_err;

    // Input handshake and frame-close decode. The counter holds the index of
    // the word now on the bus, so reaching LAST_IDX means this word fills the
    // frame and closes it regardless of in_last.
    assign accept       = in_valid && in_ready;
    assign close_frame  = in_last || (cnt == LAST_IDX);
    assign word_parity  = ^in_data;
    assign frame_parity = acc ^ word_parity ^ ODD_BIT;
    assign frame_err    = (frame_parity != in_exp);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. flush overrides everything, including a result
    // being taken by out_ready in the same cycle.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ACCUM;
        end else begin
            case (state)
                ACCUM: if (accept && close_frame) state_next = HOLD;
                HOLD:  if (out_ready)             state_next = ACCUM;
                default: state_next = ACCUM;
            endcase
        end
    end

    // Handshake outputs are pure state decodes, so there is no combinational
    // path from out_ready to in_ready.
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
    end

    // Accumulator, word counter and result registers. On the closing word the
    // running parity and count are left as they are and only cleared once the
    // result is taken (or flushed), so the next frame starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= 1'b0;
            cnt        <= '0;
            out_parity <= 1'b0;
            out_err    <= 1'b0;
            out_len    <= '0;
            err_count  <= 8'd0;
        end else if (flush) begin
            acc <= 1'b0;
            cnt <= '0;
        end else if (accept) begin
            if (close_frame) begin
                out_parity <= frame_parity;
                out_err    <= frame_err;
                out_len    <= cnt + CW'(1);
                if (frame_err && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'd1;
                end
            end else begin
                acc <= acc ^ word_parity;
                cnt <= cnt + CW'(1);
            end
        end else if ((state == HOLD) && out_ready) begin
            acc <= 1'b0;
            cnt <= '0;
        end
    end

endmodule
